// File: rtl/cpu_player.sv
// Computer-opponent press generator: emits fixed-shape press pulses whose
// start is gated by an LFSR-vs-level threshold, for the Tug of War game.
module cpu_player #(
    parameter int unsigned LFSR_W = 10,
    parameter int unsigned HOLD   = 2,
    parameter int unsigned GAP    = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [LFSR_W-1:0] level,
    output logic              press,
    output logic              busy,
    output logic [7:0]        press_count
);

    localparam int unsigned CNT_W = 4;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PRESS = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [LFSR_W-1:0] lfsr;
    logic [LFSR_W-1:0] lfsr_nxt;
    logic              fire;

    // XNOR Fibonacci, taps 10 and 7; all-ones is the unreachable lock-up state
    assign lfsr_nxt = {lfsr[LFSR_W-2:0], ~(lfsr[LFSR_W-1] ^ lfsr[LFSR_W-4])};

    // Next-state and counter decode
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        fire      = 1'b0;
        case (state)
            S_IDLE: begin
                if (enable && (lfsr < level)) begin
                    state_nxt = S_PRESS;
                    cnt_nxt   = CNT_W'(HOLD - 1);
                    fire      = 1'b1;
                end
            end
            S_PRESS: begin
                if (cnt == '0) begin
                    state_nxt = S_GAP;
                    cnt_nxt   = CNT_W'(GAP - 1);
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            S_GAP: begin
                if (cnt == '0) begin
                    state_nxt = S_IDLE;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // State, LFSR and registered Moore outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            lfsr        <= '0;
            press       <= 1'b0;
            busy        <= 1'b0;
            press_count <= 8'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            lfsr  <= lfsr_nxt;
            press <= (state_nxt == S_PRESS);
            busy  <= (state_nxt != S_IDLE);
            if (fire && (press_count != 8'hFF)) begin
                press_count <= press_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_cpu_player.sv
// Self-checking bench for cpu_player: directed scenarios plus randomized
// stimulus compared against a remaining-busy-cycles reference model.
module tb_cpu_player;

    localparam int HOLD = 2;
    localparam int GAP  = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [9:0] level = 10'd0;
    logic       press;
    logic       busy;
    logic [7:0] press_count;

    int checks = 0;
    int failures = 0;

    // Reference model: cycles of busy time left, pseudo-random value, presses started
    int         m_rem = 0;
    logic [9:0] m_lfsr = 10'd0;
    int         m_cnt = 0;

    cpu_player #(.LFSR_W(10), .HOLD(HOLD), .GAP(GAP)) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .level(level),
        .press(press),
        .busy(busy),
        .press_count(press_count)
    );

    always #5 clk = ~clk;

    // One clock: advance the model on the edge, then settle for sampling
    task automatic cycle();
        @(posedge clk);
        if (reset) begin
            m_rem  = 0;
            m_lfsr = 10'd0;
            m_cnt  = 0;
        end else begin
            if (m_rem == 0) begin
                if (enable && (m_lfsr < level)) begin
                    m_rem = HOLD + GAP;
                    if (m_cnt < 255) m_cnt = m_cnt + 1;
                end
            end else begin
                m_rem = m_rem - 1;
            end
            m_lfsr = {m_lfsr[8:0], ~(m_lfsr[9] ^ m_lfsr[6])};
        end
        #1;
    endtask

    task automatic do_reset(input logic en, input logic [9:0] lvl);
        enable = en;
        level  = lvl;
        reset  = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        enable = 1'b1;
        level  = 10'h3FF;
        reset  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cycle();
            checks++;
            if (press !== 1'b0) begin failures++; $display("FAIL reset_press got=%b want=0", press); end
            checks++;
            if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
            checks++;
            if (press_count !== 8'd0) begin failures++; $display("FAIL reset_count got=%0d want=0", press_count); end
        end
        reset = 1'b0;
        cycle();
        checks++;
        if (press !== 1'b1 || busy !== 1'b1) begin
            failures++; $display("FAIL reset_first_press got press=%b busy=%b want 1 1", press, busy);
        end
        checks++;
        if (press_count !== 8'd1) begin failures++; $display("FAIL reset_first_count got=%0d want=1", press_count); end
    endtask

    task automatic test_max_rate();
        logic ep, eb;
        do_reset(1'b1, 10'h3FF);
        for (int i = 0; i < 25; i++) begin
            cycle();
            ep = ((i % 5) < 2);
            eb = ((i % 5) < 4);
            checks++;
            if (press !== ep) begin failures++; $display("FAIL max_press cyc=%0d got=%b want=%b", i, press, ep); end
            checks++;
            if (busy !== eb) begin failures++; $display("FAIL max_busy cyc=%0d got=%b want=%b", i, busy, eb); end
        end
        checks++;
        if (press_count !== 8'd5) begin failures++; $display("FAIL max_count got=%0d want=5", press_count); end
    endtask

    task automatic test_min_rate();
        logic prev;
        int   rises;
        int   pos[$];
        do_reset(1'b1, 10'd1);
        prev  = 1'b0;
        rises = 0;
        for (int i = 1; i <= 3069; i++) begin
            cycle();
            checks++;
            if (press !== (m_rem > GAP)) begin
                failures++; $display("FAIL min_press cyc=%0d got=%b want=%b", i, press, (m_rem > GAP));
            end
            if (press && !prev) begin
                rises++;
                pos.push_back(i);
            end
            prev = press;
        end
        checks++;
        if (rises != 3) begin failures++; $display("FAIL min_rises got=%0d want=3", rises); end
        for (int k = 0; k < pos.size() && k < 3; k++) begin
            checks++;
            if (pos[k] != 1 + 1023 * k) begin
                failures++; $display("FAIL min_rise_pos idx=%0d got=%0d want=%0d", k, pos[k], 1 + 1023 * k);
            end
        end
        checks++;
        if (press_count !== 8'd3) begin failures++; $display("FAIL min_count got=%0d want=3", press_count); end

        do_reset(1'b1, 10'd0);
        rises = 0;
        for (int i = 0; i < 2046; i++) begin
            cycle();
            if (press) rises++;
        end
        checks++;
        if (rises != 0) begin failures++; $display("FAIL zero_level_presses got=%0d want=0", rises); end
        checks++;
        if (press_count !== 8'd0) begin failures++; $display("FAIL zero_level_count got=%0d want=0", press_count); end
    endtask

    task automatic test_enable_mid_press();
        logic ep, eb;
        do_reset(1'b1, 10'h3FF);
        cycle();
        checks++;
        if (press !== 1'b1) begin failures++; $display("FAIL en_first_press got=%b want=1", press); end
        enable = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            cycle();
            ep = (k == 1);
            eb = (k <= 3);
            checks++;
            if (press !== ep || busy !== eb) begin
                failures++; $display("FAIL en_drop cyc=%0d got press=%b busy=%b want %b %b", k, press, busy, ep, eb);
            end
        end
        checks++;
        if (press_count !== 8'd1) begin failures++; $display("FAIL en_count got=%0d want=1", press_count); end
    endtask

    task automatic test_reset_mid_press();
        do_reset(1'b1, 10'h3FF);
        cycle();
        cycle();
        checks++;
        if (press !== 1'b1) begin failures++; $display("FAIL rmid_second_press got=%b want=1", press); end
        reset = 1'b1;
        level = 10'd1;
        cycle();
        checks++;
        if (press !== 1'b0 || busy !== 1'b0 || press_count !== 8'd0) begin
            failures++; $display("FAIL rmid_reset got press=%b busy=%b count=%0d want 0 0 0", press, busy, press_count);
        end
        reset = 1'b0;
        cycle();
        checks++;
        if (press !== 1'b1 || press_count !== 8'd1) begin
            failures++; $display("FAIL rmid_restart got press=%b count=%0d want 1 1", press, press_count);
        end
        for (int k = 0; k < 6; k++) begin
            cycle();
            checks++;
            if (press !== (m_rem > GAP) || busy !== (m_rem != 0)) begin
                failures++; $display("FAIL rmid_after cyc=%0d got press=%b busy=%b want %b %b", k, press, busy, (m_rem > GAP), (m_rem != 0));
            end
        end
    endtask

    task automatic test_saturation();
        logic ep;
        do_reset(1'b1, 10'h3FF);
        for (int i = 0; i < 1300; i++) begin
            cycle();
            ep = ((i % 5) < 2);
            checks++;
            if (press !== ep) begin failures++; $display("FAIL sat_press cyc=%0d got=%b want=%b", i, press, ep); end
            checks++;
            if (press_count !== 8'(m_cnt)) begin
                failures++; $display("FAIL sat_count cyc=%0d got=%0d want=%0d", i, press_count, m_cnt);
            end
        end
        checks++;
        if (press_count !== 8'd255) begin failures++; $display("FAIL sat_final got=%0d want=255", press_count); end
    endtask

    task automatic test_random();
        do_reset(1'b1, 10'd512);
        for (int i = 0; i < 3000; i++) begin
            if ((i % 50) == 0) level = 10'($urandom_range(0, 1023));
            enable = ($urandom_range(0, 3) != 0);
            reset  = ($urandom_range(0, 499) == 0);
            cycle();
            checks++;
            if (press !== (m_rem > GAP) || busy !== (m_rem != 0) || press_count !== 8'(m_cnt)) begin
                failures++;
                $display("FAIL rand cyc=%0d got press=%b busy=%b count=%0d want %b %b %0d",
                         i, press, busy, press_count, (m_rem > GAP), (m_rem != 0), m_cnt);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_max_rate();
        test_min_rate();
        test_enable_mid_press();
        test_reset_mid_press();
        test_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
